// File: rtl/mbank_port_arbiter.sv
`timescale 1ns/1ps
// Purpose: two-port arbiter/sequencer in front of one single-port multi-bank SPRAM.
// Latency: ready is combinational in IDLE (cycle T); mem_en T+1..T+LAT; rsp_valid pulse at T+LAT+1.
// Backpressure: only the selected valid port sees ready, and only in IDLE; others simply hold valid.
//
// Ports: clk/rst (async active-high); p0_*/p1_* valid-ready request (we/addr/wdata) plus
// rsp_valid pulse and held rdata per port; mem_* drive the SPRAM while a transaction runs,
// mem_dout returns read data; busy flags RUN or DONE.
// Build option: define MBARB_FIXED_PRIO_EN to make port 0 win every tie (no round-robin).
module mbank_port_arbiter #(
  parameter int WRITE_LATENCY = 2,
  parameter int READ_LATENCY  = 2,
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count of the final enable cycle for each access type.
  localparam logic [3:0] WR_LAST = 4'(WRITE_LATENCY - 1);
  localparam logic [3:0] RD_LAST = 4'(READ_LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        count;
  logic              last_grant;
  logic              gnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              sel_port;
  logic              accept;
  logic              run_last;

  // Port selection among valid requesters.
  always_comb begin
`ifdef MBARB_FIXED_PRIO_EN
    sel_port = ~p0_valid;
`else
    if (p0_valid && p1_valid) begin
      sel_port = ~last_grant;
    end else begin
      sel_port = ~p0_valid;
    end
`endif
  end

  assign run_last = (count == (lat_we ? WR_LAST : RD_LAST));
  assign accept   = p0_ready | p1_ready;

  // Next state and all non-data outputs. Ready is gated by rst so every
  // output reads 0 while reset is held.
  always_comb begin
    state_nxt    = state;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (p0_valid || p1_valid)) begin
          p0_ready  = ~sel_port;
          p1_ready  = sel_port;
          state_nxt = RUN;
        end
      end
      RUN: begin
        mem_en   = 1'b1;
        mem_we   = lat_we;
        mem_addr = lat_addr;
        mem_din  = lat_wdata;
        busy     = 1'b1;
        if (run_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        p0_rsp_valid = ~gnt;
        p1_rsp_valid = gnt;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture: the requester is free to change its inputs after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (accept) begin
      last_grant <= p1_ready;
      gnt        <= p1_ready;
      lat_we     <= p1_ready ? p1_we    : p0_we;
      lat_addr   <= p1_ready ? p1_addr  : p0_addr;
      lat_wdata  <= p1_ready ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state == RUN) begin
      count <= count + 4'd1;
    end else begin
      count <= '0;
    end
  end

  // Read data is valid on the last enable cycle; only the granted port's
  // copy is updated, the other keeps its previous read value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (state == RUN && !lat_we && count == RD_LAST) begin
      if (gnt) begin
        p1_rdata <= mem_dout;
      end else begin
        p0_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: doc/mbank_port_arbiter.md
Name: mbank_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port multi-bank SPRAM datapath.
- Gives two independent ports (p0, p1) a valid/ready request and response-pulse interface onto one memory.
- Grants one port at a time, holds the memory enable for the configured read/write latency, captures read data and returns a single-cycle response to the granted port.
- Sits between the AXI-side channel logic and the SPRAM.

Parameters:
- WRITE_LATENCY, 2, memory enable cycles per write; legal range 1..15
- READ_LATENCY, 2, memory enable cycles per read; read data valid on the last of them; legal range 1..15
- ADDR_W, 5, address width
- DATA_W, 8, data width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- p0_valid  input  1  port 0 request valid
- p0_ready  output  1  port 0 request accepted this cycle
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  ADDR_W  port 0 address
- p0_wdata  input  DATA_W  port 0 write data
- p0_rsp_valid  output  1  port 0 response pulse
- p0_rdata  output  DATA_W  port 0 read data
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rsp_valid, p1_rdata: identical to the p0 ports, for port 1
- mem_en  output  1  SPRAM enable
- mem_we  output  1  SPRAM write enable
- mem_addr  output  ADDR_W  SPRAM address
- mem_din  output  DATA_W  SPRAM write data
- mem_dout  input  DATA_W  SPRAM read data
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values: state IDLE, count 0, last_grant 1 (so port 0 wins the first tie). All outputs 0: px_ready, px_rsp_valid, px_rdata, mem_*, busy.
- IDLE:
  - px_ready is combinational and goes high only to the selected port, only when its px_valid=1.
  - Selection: if only one port is valid, that port wins. If both are valid, the port != last_grant wins (round-robin).
  - On acceptance, latch gnt, we, addr and wdata into registers; last_grant<=gnt; count<=0; go to RUN.
  - After acceptance the requester may change its inputs freely.
- RUN:
  - mem_en=1; mem_we/mem_addr/mem_din driven from the latched registers; count increments each cycle.
  - Leave RUN when count==LAT-1 (LAT = WRITE_LATENCY or READ_LATENCY per latched we), then go to DONE.
  - Read: on the cycle count==READ_LATENCY-1, register mem_dout into rdata of the granted port only.
  - Occupancy: exactly LAT cycles with mem_en=1.
- DONE:
  - mem_en=0; px_rsp_valid=1 for exactly one cycle on the granted port (reads and writes); go to IDLE.
- Both px_ready=0 outside IDLE. A request held through RUN/DONE is accepted in the next IDLE.
- Transaction timing: accept cycle T; mem_en high T+1..T+LAT; rsp_valid at T+LAT+1; next accept earliest T+LAT+2.
- px_rdata holds its last read value until that port's next read completes; writes leave it unchanged.
- The non-granted port's rdata and rsp_valid are unaffected.
- mem_* outputs are 0 when not in RUN.
- Reset mid-transaction: immediate asynchronous return to reset values. No rsp_valid is issued; the aborted request is not retried.
- Simultaneous p0_valid and p1_valid in consecutive IDLE visits: grants alternate 0,1,0,1.
- A px_valid deassertion while in IDLE before acceptance is legal; no grant.

Optional Feature:
- Macro MBARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a tie; last_grant is unused.
- Undefined: round-robin as described above.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then p0 write addr=5 data=0xA5 (WRITE_LATENCY=2) -> p0_ready at T, mem_en/mem_we=1 at T+1..T+2 with mem_addr=5 and mem_din=0xA5, p0_rsp_valid at T+3, p1 outputs stay 0.
- p1 read addr=5 after the write above, READ_LATENCY=2, SPRAM model returning 0xA5 -> p1_rsp_valid at T+3, p1_rdata=0xA5, p0_rdata still 0.
- p0 and p1 both hold valid reads for 4 transactions -> grant order 0,1,0,1; with MBARB_FIXED_PRIO_EN -> 0,0,0,0 while p0 stays valid.
- READ_LATENCY=4, WRITE_LATENCY=1, interleaved write/read -> mem_en high 1 cycle for the write and 4 cycles for the read; rdata sampled on the 4th cycle.
- Assert rst during RUN of a read (count=1) -> mem_en=0 and busy=0 immediately; no rsp_valid; state IDLE after release; a fresh request is then accepted normally.
- p0 changes its addr/wdata one cycle after acceptance -> mem_addr/mem_din keep the latched values for the whole RUN.
